mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing one single-ported, fixed-latency synchronous memory between the core's instruction-fetch port and its load/store port. It grants at most one access per cycle with round-robin priority and tracks in-flight accesses so each read response returns to the requester that issued it. It sits between the core and a unified instruction/data RAM, replacing the separate instruction and data memories.

## Interface
Parameters:
- MEM_LAT, 1, memory read latency in cycles (legal range 1..4)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DW  fetch data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  load/store address
- d_wdata  in  DW  store data
- d_gnt  out  1  load/store accepted this cycle
- d_rvalid  out  1  load data valid, or store acknowledge
- d_rdata  out  DW  load data; 0 on a store acknowledge
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after the m_en cycle
- conflicts  out  16  count of cycles with both requests asserted; saturates at 0xFFFF

## Operation
- Grants are combinational from the requests.
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the requester not granted most recently wins.
- Last-winner register (`last`): updates on every grant. Reset value SRC_I, so D wins the first conflict.
- Granted requester drives m_we, m_addr and m_wdata. m_en = i_gnt | d_gnt.
  - A fetch always drives m_we = 0 and m_wdata = 0.
  - With no grant, m_we = 0 and m_addr/m_wdata = 0.
- Response tracking: each grant pushes a tag {valid, src, is_write} into a MEM_LAT-deep shift register.
  - When the head tag is valid, the response is routed to its source: xx_rvalid = 1 and xx_rdata = m_rdata.
  - A store tag produces d_rvalid = 1 with d_rdata = 0.
  - The non-addressed port drives rvalid = 0 and rdata = 0.
- Requesters hold req and its address/data stable until gnt; the arbiter does not latch ungranted requests.
- Throughput: one grant per cycle, fully pipelined, no limit on outstanding accesses.
- Store tags are pushed like loads, so response ordering matches grant ordering per port.
- conflicts increments in every cycle where i_req & d_req, and saturates at 0xFFFF.

## Timing
- Grant latency is 0 cycles: gnt is asserted in the same cycle as req when the requester wins.
- Response latency is exactly MEM_LAT cycles: a grant in cycle t gives rvalid in cycle t+MEM_LAT.
- Under continuous contention the two ports alternate, so a requester waits at most 1 cycle.
- Grants and returning responses in the same cycle are independent.
- While reset is high, all outputs are 0: gnts, m_en, rvalids, rdata, m_* and conflicts.
- Reset asserted mid-operation:
  - The tag pipeline is cleared, so in-flight responses are discarded and never reported.
  - `last` returns to SRC_I.
  - conflicts clears to 0.
- First grant possible in the cycle after reset deasserts.

## Structure
- Package mem_arb_pkg:
  - typedef enum logic {SRC_I, SRC_D} src_t
  - packed struct tag_t {logic valid; src_t src; logic is_write;}
  - localparam MAX_LAT = 4
- Sub-module resp_pipe: a parameterised MEM_LAT-deep shift register of tag_t with synchronous clear on reset. It outputs the head tag.
- Arbitration, muxing and the counter live in mem_arbiter itself.

## Test plan
- Idle, then a single fetch: i_req=1, i_addr=0x100, memory returns 0xDEADBEEF. Expect i_gnt=1 in the same cycle, m_addr=0x100, m_we=0, then i_rvalid=1 with i_rdata=0xDEADBEEF after MEM_LAT cycles; d_rvalid stays 0.
- Store then load to the same address: d_we=1, d_addr=0x40, d_wdata=0x12345678, then a load of 0x40. Expect d_rvalid with d_rdata=0 for the store, then d_rdata=0x12345678 for the load.
- Both ports request continuously for 8 cycles after reset:
  - Grants alternate D, I, D, I, …, 4 each.
  - conflicts = 8.
  - Responses arrive in grant order on the correct ports.
- Back-to-back fetches at 0x0, 0x4 and 0x8 with MEM_LAT=3: three consecutive grants and three consecutive i_rvalid cycles with the matching data, no gaps.
- Reset asserted while 2 loads are in flight: no d_rvalid after reset, all outputs 0 during reset, and the first post-reset conflict is granted to D.
- Force 70000 conflict cycles: conflicts holds at 0xFFFF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: requester id, in-flight tag,
// and the supported latency bound.
package mem_arb_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  typedef struct packed {
    logic valid;
    src_t src;
    logic is_write;
  } tag_t;

  localparam int unsigned MAX_LAT = 4;

endpackage

// File: rtl/resp_pipe.sv
// Fixed-depth tag shift register matching the memory read latency; the head
// tag identifies who owns the m_rdata beat arriving this cycle.
module resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t push,
  output tag_t head
);

  tag_t stage [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(LAT); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push;
      for (int i = 1; i < int'(LAT); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign head = stage[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency synchronous RAM between the
// fetch port and the load/store port, with per-port response routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [15:0]   conflicts
);

  if (MEM_LAT < 1 || MEM_LAT > MAX_LAT) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT out of range");
  end

  src_t        last;
  logic        both;
  logic        i_win;
  logic        d_win;
  tag_t        push;
  tag_t        head;
  logic [15:0] conf_cnt;

  assign both = i_req & d_req;

  // On contention the port that did not win last time goes first.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!reset) begin
      if (both) begin
        d_win = (last == SRC_I);
        i_win = (last == SRC_D);
      end else begin
        i_win = i_req;
        d_win = d_req;
      end
    end
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;
  assign m_en  = i_win | d_win;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (d_win) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_win) begin
      m_addr  = i_addr;
    end
  end

  always_comb begin
    push          = '0;
    push.valid    = m_en;
    push.src      = d_win ? SRC_D : SRC_I;
    push.is_write = d_win & d_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= SRC_I;
    end else if (d_win) begin
      last <= SRC_D;
    end else if (i_win) begin
      last <= SRC_I;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conf_cnt <= '0;
    end else if (both && conf_cnt != 16'hFFFF) begin
      conf_cnt <= conf_cnt + 16'd1;
    end
  end

  assign conflicts = reset ? 16'd0 : conf_cnt;

  resp_pipe #(
    .LAT (MEM_LAT)
  ) u_resp_pipe (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .head  (head)
  );

  // Stores acknowledge on the data port with zero data.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (!reset && head.valid) begin
      if (head.src == SRC_D) begin
        d_rvalid = 1'b1;
        d_rdata  = head.is_write ? '0 : m_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
    end
  end

endmodule
